// File: rtl/mem_access_ctrl_if.sv
// Bus interface for mem_access_ctrl.
// Groups the fetch port, the load/store port, the memory port and the busy flag.
//   slave  : controller view (i* are inputs, o* are outputs)
//   master : environment view (drives i*, observes o*)
`timescale 1ns/1ps
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned INST_WIDTH = 32
);
  // Fetch port
  logic                  iInstReq;
  logic [ADDR_WIDTH-1:0] iInstAddr;
  logic                  oInstValid;
  logic [INST_WIDTH-1:0] oInst;
  // Load/store port
  logic                  iLsReq;
  logic                  iLsWr;
  logic [ADDR_WIDTH-1:0] iLsAddr;
  logic [DATA_WIDTH-1:0] iLsWrData;
  logic [3:0]            iLsLen;
  logic                  iLsSigned;
  logic                  oLsDone;
  logic [DATA_WIDTH-1:0] oLsRdData;
  logic                  oLsErr;
  // Memory port
  logic                  oMemReqValid;
  logic                  iMemReqReady;
  logic                  oMemWrEn;
  logic [ADDR_WIDTH-1:0] oMemAddr;
  logic [DATA_WIDTH-1:0] oMemWrData;
  logic [7:0]            oMemWrStrb;
  logic                  iMemRespValid;
  logic [DATA_WIDTH-1:0] iMemRespData;
  // Status
  logic                  oBusy;

  modport slave (
    input  iInstReq, iInstAddr,
    input  iLsReq, iLsWr, iLsAddr, iLsWrData, iLsLen, iLsSigned,
    input  iMemReqReady, iMemRespValid, iMemRespData,
    output oInstValid, oInst,
    output oLsDone, oLsRdData, oLsErr,
    output oMemReqValid, oMemWrEn, oMemAddr, oMemWrData, oMemWrStrb,
    output oBusy
  );

  modport master (
    output iInstReq, iInstAddr,
    output iLsReq, iLsWr, iLsAddr, iLsWrData, iLsLen, iLsSigned,
    output iMemReqReady, iMemRespValid, iMemRespData,
    input  oInstValid, oInst,
    input  oLsDone, oLsRdData, oLsErr,
    input  oMemReqValid, oMemWrEn, oMemAddr, oMemWrData, oMemWrStrb,
    input  oBusy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates one instruction fetch or one load/store at a time
// onto a single 64-bit memory port (request/ready handshake, then response valid).
// Ports:
//   iClock - clock
//   iReset - asynchronous active-low reset
//   bus    - mem_access_ctrl_if.slave: fetch, load/store, memory port and oBusy
// All outputs are decoded from registered state, so they are glitch-free and held stable
// while a memory request waits for iMemReqReady.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic               iClock,
  input  logic               iReset,
  mem_access_ctrl_if.slave   bus
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  is_ls_q, is_ls_d;    // request being served is a load/store
  logic                  wr_q, wr_d;
  logic                  sgn_q, sgn_d;
  logic                  err_q, err_d;        // rejected or timed out
  logic [3:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;      // memory response, zeroed on error
  logic [CntW-1:0]       cnt_q, cnt_d;

  // Validity of the incoming load/store: legal length and natural alignment.
  logic       len_ok;
  logic [2:0] len_mask;
  logic       ls_bad;

  always_comb begin
    len_ok   = 1'b1;
    len_mask = 3'd0;
    case (bus.iLsLen)
      4'd1:    len_mask = 3'd0;
      4'd2:    len_mask = 3'd1;
      4'd4:    len_mask = 3'd3;
      4'd8:    len_mask = 3'd7;
      default: len_ok   = 1'b0;
    endcase
    ls_bad = !len_ok || ((bus.iLsAddr[2:0] & len_mask) != 3'd0);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    is_ls_d = is_ls_q;
    wr_d    = wr_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.iLsReq) begin
          is_ls_d = 1'b1;
          wr_d    = bus.iLsWr;
          sgn_d   = bus.iLsSigned;
          len_d   = bus.iLsLen;
          addr_d  = bus.iLsAddr;
          wdata_d = bus.iLsWrData;
          data_d  = '0;
          err_d   = ls_bad;
          state_d = ls_bad ? StResp : StReq;
        end else if (bus.iInstReq) begin
          is_ls_d = 1'b0;
          wr_d    = 1'b0;
          sgn_d   = 1'b0;
          len_d   = 4'd4;
          addr_d  = bus.iInstAddr;
          wdata_d = '0;
          data_d  = '0;
          err_d   = (bus.iInstAddr[1:0] != 2'b00);
          state_d = err_d ? StResp : StReq;
        end
      end
      StReq: begin
        // Responses in this state are ignored, including one coincident with the handshake.
        if (bus.iMemReqReady) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.iMemRespValid) begin
          data_d  = bus.iMemRespData;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= StIdle;
      is_ls_q <= 1'b0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      is_ls_q <= is_ls_d;
      wr_q    <= wr_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte lane mask for a store, before shifting to the address offset.
  logic [7:0]            lane_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_data;

  always_comb begin
    case (len_q)
      4'd1:    lane_mask = 8'h01;
      4'd2:    lane_mask = 8'h03;
      4'd4:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  end

  // Load extraction: move the addressed bytes down to bit 0, then extend.
  always_comb begin
    shifted = data_q >> {addr_q[2:0], 3'b000};
    case (len_q)
      4'd1:    ld_data = {{(DATA_WIDTH-8){sgn_q & shifted[7]}}, shifted[7:0]};
      4'd2:    ld_data = {{(DATA_WIDTH-16){sgn_q & shifted[15]}}, shifted[15:0]};
      4'd4:    ld_data = {{(DATA_WIDTH-32){sgn_q & shifted[31]}}, shifted[31:0]};
      default: ld_data = shifted;
    endcase
  end

  // Outputs are forced to zero outside the state that owns them.
  always_comb begin
    bus.oBusy        = (state_q != StIdle);
    bus.oMemReqValid = 1'b0;
    bus.oMemWrEn     = 1'b0;
    bus.oMemAddr     = '0;
    bus.oMemWrData   = '0;
    bus.oMemWrStrb   = 8'h00;
    bus.oInstValid   = 1'b0;
    bus.oInst        = '0;
    bus.oLsDone      = 1'b0;
    bus.oLsErr       = 1'b0;
    bus.oLsRdData    = '0;

    if (state_q == StReq) begin
      bus.oMemReqValid = 1'b1;
      bus.oMemAddr     = {addr_q[ADDR_WIDTH-1:3], 3'b000};
      if (wr_q) begin
        bus.oMemWrEn   = 1'b1;
        bus.oMemWrData = wdata_q << {addr_q[2:0], 3'b000};
        bus.oMemWrStrb = lane_mask << addr_q[2:0];
      end
    end

    if (state_q == StResp) begin
      if (is_ls_q) begin
        bus.oLsDone = 1'b1;
        bus.oLsErr  = err_q;
        if (!wr_q && !err_q) begin
          bus.oLsRdData = ld_data;
        end
      end else begin
        bus.oInstValid = 1'b1;
        bus.oInst      = addr_q[2] ? data_q[2*INST_WIDTH-1:INST_WIDTH]
                                   : data_q[INST_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_access_ctrl_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .INST_WIDTH(32)) bus ();

  mem_access_ctrl #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64),
    .INST_WIDTH(32),
    .TIMEOUT   (256)
  ) dut (
    .iClock(clk),
    .iReset(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full load with ready high and an immediate response.
  task automatic do_load(input string tag, input logic [63:0] addr, input logic [3:0] len,
                         input logic sgn, input logic [63:0] mem, input logic [63:0] exp);
    bus.iLsReq = 1'b1; bus.iLsWr = 1'b0; bus.iLsAddr = addr;
    bus.iLsLen = len;  bus.iLsSigned = sgn; bus.iMemReqReady = 1'b1;
    tick();
    bus.iLsReq = 1'b0;
    chk({tag, "_addr"}, bus.oMemAddr, {addr[63:3], 3'b000});
    tick();
    bus.iMemRespValid = 1'b1; bus.iMemRespData = mem;
    tick();
    bus.iMemRespValid = 1'b0;
    chk({tag, "_done"}, {63'd0, bus.oLsDone}, 64'd1);
    chk({tag, "_data"}, bus.oLsRdData, exp);
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.iInstReq = 1'b0; bus.iInstAddr = '0;
    bus.iLsReq = 1'b0; bus.iLsWr = 1'b0; bus.iLsAddr = '0; bus.iLsWrData = '0;
    bus.iLsLen = 4'd0; bus.iLsSigned = 1'b0;
    bus.iMemReqReady = 1'b0; bus.iMemRespValid = 1'b0; bus.iMemRespData = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", {63'd0, bus.oBusy}, 64'd0);
    chk("rst_reqv", {63'd0, bus.oMemReqValid}, 64'd0);
    chk("rst_done", {63'd0, bus.oLsDone}, 64'd0);
    chk("rst_ival", {63'd0, bus.oInstValid}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Signed halfword load, ready tied high: done on the third edge after acceptance
    bus.iLsReq = 1'b1; bus.iLsWr = 1'b0; bus.iLsAddr = 64'h8000_0006;
    bus.iLsLen = 4'd2; bus.iLsSigned = 1'b1; bus.iMemReqReady = 1'b1;
    tick();
    bus.iLsReq = 1'b0;
    chk("ld_reqv", {63'd0, bus.oMemReqValid}, 64'd1);
    chk("ld_addr", bus.oMemAddr, 64'h8000_0000);
    chk("ld_wren", {63'd0, bus.oMemWrEn}, 64'd0);
    chk("ld_strb", {56'd0, bus.oMemWrStrb}, 64'd0);
    chk("ld_busy", {63'd0, bus.oBusy}, 64'd1);
    tick();
    chk("ld_wait_done", {63'd0, bus.oLsDone}, 64'd0);
    bus.iMemRespValid = 1'b1; bus.iMemRespData = 64'hABCD_0000_0000_0000;
    tick();
    bus.iMemRespValid = 1'b0;
    chk("ld_done", {63'd0, bus.oLsDone}, 64'd1);
    chk("ld_err", {63'd0, bus.oLsErr}, 64'd0);
    chk("ld_data", bus.oLsRdData, 64'hFFFF_FFFF_FFFF_ABCD);
    tick();
    chk("ld_idle_done", {63'd0, bus.oLsDone}, 64'd0);
    chk("ld_idle_busy", {63'd0, bus.oBusy}, 64'd0);

    // Store under 5 cycles of backpressure; a response during REQ must be ignored
    bus.iLsReq = 1'b1; bus.iLsWr = 1'b1; bus.iLsAddr = 64'h8000_0004;
    bus.iLsLen = 4'd4; bus.iLsWrData = 64'h1122_3344; bus.iMemReqReady = 1'b0;
    tick();
    bus.iLsReq = 1'b0; bus.iLsWr = 1'b0;
    bus.iMemRespValid = 1'b1; bus.iMemRespData = 64'h5555_5555_5555_5555;
    chk("st_strb", {56'd0, bus.oMemWrStrb}, 64'hF0);
    chk("st_wdata", bus.oMemWrData, 64'h1122_3344_0000_0000);
    chk("st_wren", {63'd0, bus.oMemWrEn}, 64'd1);
    chk("st_addr", bus.oMemAddr, 64'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_reqv", {63'd0, bus.oMemReqValid}, 64'd1);
      chk("bp_addr", bus.oMemAddr, 64'h8000_0000);
      chk("bp_wdata", bus.oMemWrData, 64'h1122_3344_0000_0000);
      chk("bp_strb", {56'd0, bus.oMemWrStrb}, 64'hF0);
    end
    bus.iMemReqReady = 1'b1;
    tick();
    bus.iMemRespValid = 1'b0;
    chk("st_wait_reqv", {63'd0, bus.oMemReqValid}, 64'd0);
    tick();
    chk("st_ign_done", {63'd0, bus.oLsDone}, 64'd0);
    chk("st_ign_busy", {63'd0, bus.oBusy}, 64'd1);
    bus.iMemRespValid = 1'b1; bus.iMemRespData = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    bus.iMemRespValid = 1'b0;
    chk("st_done", {63'd0, bus.oLsDone}, 64'd1);
    chk("st_err", {63'd0, bus.oLsErr}, 64'd0);
    chk("st_rdata", bus.oLsRdData, 64'd0);
    tick();

    // Simultaneous requests: load/store first, fetch accepted in the following IDLE cycle
    bus.iInstReq = 1'b1; bus.iInstAddr = 64'h1004;
    bus.iLsReq = 1'b1; bus.iLsWr = 1'b0; bus.iLsAddr = 64'h10; bus.iLsLen = 4'd8;
    bus.iLsSigned = 1'b0;
    tick();
    bus.iLsReq = 1'b0;
    chk("pri_addr", bus.oMemAddr, 64'h10);
    tick();
    bus.iMemRespValid = 1'b1; bus.iMemRespData = 64'h0123_4567_89AB_CDEF;
    tick();
    bus.iMemRespValid = 1'b0;
    chk("pri_lsdone", {63'd0, bus.oLsDone}, 64'd1);
    chk("pri_ival", {63'd0, bus.oInstValid}, 64'd0);
    chk("pri_data", bus.oLsRdData, 64'h0123_4567_89AB_CDEF);
    tick();
    chk("pri_idle", {63'd0, bus.oBusy}, 64'd0);
    tick();
    bus.iInstReq = 1'b0;
    chk("f_reqv", {63'd0, bus.oMemReqValid}, 64'd1);
    chk("f_addr", bus.oMemAddr, 64'h1000);
    chk("f_wren", {63'd0, bus.oMemWrEn}, 64'd0);
    tick();
    bus.iMemRespValid = 1'b1; bus.iMemRespData = 64'hCAFE_BABE_1234_5678;
    tick();
    bus.iMemRespValid = 1'b0;
    chk("f_ival", {63'd0, bus.oInstValid}, 64'd1);
    chk("f_inst", {32'd0, bus.oInst}, 64'hCAFE_BABE);
    chk("f_lsdone", {63'd0, bus.oLsDone}, 64'd0);
    tick();

    // Misaligned load: straight to RESP with error
    bus.iLsReq = 1'b1; bus.iLsWr = 1'b0; bus.iLsAddr = 64'h8000_0003; bus.iLsLen = 4'd4;
    tick();
    bus.iLsReq = 1'b0;
    chk("mis_reqv", {63'd0, bus.oMemReqValid}, 64'd0);
    chk("mis_done", {63'd0, bus.oLsDone}, 64'd1);
    chk("mis_err", {63'd0, bus.oLsErr}, 64'd1);
    chk("mis_data", bus.oLsRdData, 64'd0);
    tick();

    // Illegal length
    bus.iLsReq = 1'b1; bus.iLsAddr = 64'h0; bus.iLsLen = 4'd3;
    tick();
    bus.iLsReq = 1'b0;
    chk("len_done", {63'd0, bus.oLsDone}, 64'd1);
    chk("len_err", {63'd0, bus.oLsErr}, 64'd1);
    tick();

    // Misaligned fetch
    bus.iInstReq = 1'b1; bus.iInstAddr = 64'h2;
    tick();
    bus.iInstReq = 1'b0;
    chk("mf_reqv", {63'd0, bus.oMemReqValid}, 64'd0);
    chk("mf_ival", {63'd0, bus.oInstValid}, 64'd1);
    chk("mf_inst", {32'd0, bus.oInst}, 64'd0);
    tick();

    // Byte and word loads, signed and unsigned
    do_load("lb_u", 64'h81, 4'd1, 1'b0, 64'h0000_0000_0000_8000, 64'h80);
    do_load("lb_s", 64'h81, 4'd1, 1'b1, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lw_s", 64'h84, 4'd4, 1'b1, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF);
    do_load("lw_n", 64'h84, 4'd4, 1'b1, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);

    // Timeout: 256 cycles in WAIT without response
    bus.iLsReq = 1'b1; bus.iLsWr = 1'b0; bus.iLsAddr = 64'h20; bus.iLsLen = 4'd1;
    tick();
    bus.iLsReq = 1'b0;
    tick();
    for (int i = 0; i < 255; i++) tick();
    chk("to_pre_done", {63'd0, bus.oLsDone}, 64'd0);
    chk("to_pre_busy", {63'd0, bus.oBusy}, 64'd1);
    tick();
    chk("to_done", {63'd0, bus.oLsDone}, 64'd1);
    chk("to_err", {63'd0, bus.oLsErr}, 64'd1);
    chk("to_data", bus.oLsRdData, 64'd0);
    tick();

    // Reset in WAIT, then a late response
    bus.iLsReq = 1'b1; bus.iLsAddr = 64'h40; bus.iLsLen = 4'd8;
    tick();
    bus.iLsReq = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rw_busy", {63'd0, bus.oBusy}, 64'd0);
    #2;
    rst_n = 1'b1;
    bus.iMemRespValid = 1'b1; bus.iMemRespData = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.iMemRespValid = 1'b0;
    chk("rw_done", {63'd0, bus.oLsDone}, 64'd0);
    chk("rw_busy2", {63'd0, bus.oBusy}, 64'd0);
    chk("rw_reqv", {63'd0, bus.oMemReqValid}, 64'd0);
    chk("rw_data", bus.oLsRdData, 64'd0);
    tick();

    // Fetch of the low word after reset recovery
    bus.iInstReq = 1'b1; bus.iInstAddr = 64'h8;
    tick();
    bus.iInstReq = 1'b0;
    chk("f2_addr", bus.oMemAddr, 64'h8);
    tick();
    bus.iMemRespValid = 1'b1; bus.iMemRespData = 64'hAAAA_AAAA_5555_5555;
    tick();
    bus.iMemRespValid = 1'b0;
    chk("f2_ival", {63'd0, bus.oInstValid}, 64'd1);
    chk("f2_inst", {32'd0, bus.oInst}, 64'h5555_5555);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
